// File: rtl/mem_stage_if.sv
// Handshake and bus bundle for the zerocore load/store stage: EX input, data-RAM port and
// write-back output. The stage is the slave; the surrounding pipeline/RAM is the master.
interface mem_stage_if;
  // EX -> MEM
  logic        exValid;
  logic        exReady;
  logic        exMemRead;
  logic        exMemWrite;
  logic [2:0]  exFunct3;
  logic [63:0] exAddr;
  logic [63:0] exStoreData;
  logic        exRdEnable;
  logic [4:0]  exRdAddr;
  logic [63:0] exPc;
  logic [31:0] exInst;
  // data RAM
  logic        RamReadEnable;
  logic [63:0] RamReadAddr;
  logic [63:0] RamReadData;
  logic        RamWriteEnable;
  logic [63:0] RamWriteAddr;
  logic [63:0] RamWriteMask;
  logic [63:0] RamWriteData;
  // MEM -> WB
  logic        wbValid;
  logic        wbRdEnable;
  logic [4:0]  wbRdAddr;
  logic [63:0] wbRdData;
  logic [63:0] wbPc;
  logic [31:0] wbInst;
  logic        wbExcept;

  modport slave (
    input  exValid, exMemRead, exMemWrite, exFunct3, exAddr, exStoreData,
    input  exRdEnable, exRdAddr, exPc, exInst, RamReadData,
    output exReady, RamReadEnable, RamReadAddr, RamWriteEnable, RamWriteAddr,
    output RamWriteMask, RamWriteData, wbValid, wbRdEnable, wbRdAddr, wbRdData,
    output wbPc, wbInst, wbExcept
  );

  modport master (
    output exValid, exMemRead, exMemWrite, exFunct3, exAddr, exStoreData,
    output exRdEnable, exRdAddr, exPc, exInst, RamReadData,
    input  exReady, RamReadEnable, RamReadAddr, RamWriteEnable, RamWriteAddr,
    input  RamWriteMask, RamWriteData, wbValid, wbRdEnable, wbRdAddr, wbRdData,
    input  wbPc, wbInst, wbExcept
  );
endinterface

// File: rtl/mem_stage.sv
// zerocore load/store stage: passes ALU results through, issues aligned doubleword RAM
// accesses with byte-lane masks, and extends returned load data for write-back.
module mem_stage #(
  parameter int unsigned RAM_LATENCY = 1
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  ld_off_q;
  logic [2:0]  ld_funct3_q;
  logic        ld_rd_en_q;

  logic        accept;
  logic        is_mem;
  logic        misaligned;
  logic        except;
  logic        rd_en;
  logic [5:0]  lane_shift;
  logic [63:0] aligned_addr;
  logic [63:0] base_mask;
  logic [63:0] ld_sh;
  logic [63:0] ld_ext;

  assign accept       = bus.exValid & bus.exReady;
  assign is_mem       = bus.exMemRead | bus.exMemWrite;
  assign rd_en        = bus.exRdEnable & (bus.exRdAddr != 5'd0);
  assign lane_shift   = {bus.exAddr[2:0], 3'b000};
  assign aligned_addr = {bus.exAddr[63:3], 3'b000};

  always_comb begin
    misaligned = 1'b0;
    base_mask  = 64'd0;
    unique case (bus.exFunct3[1:0])
      2'b00: begin
        misaligned = 1'b0;
        base_mask  = 64'h0000_0000_0000_00ff;
      end
      2'b01: begin
        misaligned = bus.exAddr[0];
        base_mask  = 64'h0000_0000_0000_ffff;
      end
      2'b10: begin
        misaligned = |bus.exAddr[1:0];
        base_mask  = 64'h0000_0000_ffff_ffff;
      end
      default: begin
        misaligned = |bus.exAddr[2:0];
        base_mask  = 64'hffff_ffff_ffff_ffff;
      end
    endcase
  end

  // 3'b111 has no RV64 load/store meaning, so it is reported like a misaligned access.
  assign except = is_mem & (misaligned | (bus.exMemRead & bus.exMemWrite) |
                            (bus.exFunct3 == 3'b111));

  assign ld_sh = bus.RamReadData >> {ld_off_q, 3'b000};

  always_comb begin
    ld_ext = ld_sh;
    case (ld_funct3_q)
      3'b000:  ld_ext = {{56{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_ext = {{48{ld_sh[15]}}, ld_sh[15:0]};
      3'b010:  ld_ext = {{32{ld_sh[31]}}, ld_sh[31:0]};
      3'b100:  ld_ext = {56'd0, ld_sh[7:0]};
      3'b101:  ld_ext = {48'd0, ld_sh[15:0]};
      3'b110:  ld_ext = {32'd0, ld_sh[31:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= StIdle;
      cnt_q              <= 3'd0;
      ld_off_q           <= 3'd0;
      ld_funct3_q        <= 3'd0;
      ld_rd_en_q         <= 1'b0;
      bus.exReady        <= 1'b0;
      bus.RamReadEnable  <= 1'b0;
      bus.RamReadAddr    <= 64'd0;
      bus.RamWriteEnable <= 1'b0;
      bus.RamWriteAddr   <= 64'd0;
      bus.RamWriteMask   <= 64'd0;
      bus.RamWriteData   <= 64'd0;
      bus.wbValid        <= 1'b0;
      bus.wbRdEnable     <= 1'b0;
      bus.wbRdAddr       <= 5'd0;
      bus.wbRdData       <= 64'd0;
      bus.wbPc           <= 64'd0;
      bus.wbInst         <= 32'd0;
      bus.wbExcept       <= 1'b0;
    end else begin
      // RAM strobes and WB qualifiers are single-cycle pulses; payloads hold otherwise.
      bus.RamReadEnable  <= 1'b0;
      bus.RamReadAddr    <= 64'd0;
      bus.RamWriteEnable <= 1'b0;
      bus.RamWriteAddr   <= 64'd0;
      bus.RamWriteMask   <= 64'd0;
      bus.RamWriteData   <= 64'd0;
      bus.wbValid        <= 1'b0;
      bus.wbRdEnable     <= 1'b0;
      bus.wbExcept       <= 1'b0;

      case (state_q)
        StIdle: begin
          bus.exReady <= 1'b1;
          if (accept) begin
            bus.wbPc     <= bus.exPc;
            bus.wbInst   <= bus.exInst;
            bus.wbRdAddr <= bus.exRdAddr;
            if (except) begin
              bus.wbValid  <= 1'b1;
              bus.wbExcept <= 1'b1;
              bus.wbRdData <= 64'd0;
            end else if (bus.exMemWrite) begin
              bus.wbValid        <= 1'b1;
              bus.wbRdData       <= 64'd0;
              bus.RamWriteEnable <= 1'b1;
              bus.RamWriteAddr   <= aligned_addr;
              bus.RamWriteMask   <= base_mask << lane_shift;
              bus.RamWriteData   <= bus.exStoreData << lane_shift;
            end else if (bus.exMemRead) begin
              bus.RamReadEnable <= 1'b1;
              bus.RamReadAddr   <= aligned_addr;
              bus.exReady       <= 1'b0;
              state_q           <= StWait;
              cnt_q             <= 3'(RAM_LATENCY);
              ld_off_q          <= bus.exAddr[2:0];
              ld_funct3_q       <= bus.exFunct3;
              ld_rd_en_q        <= rd_en;
            end else begin
              bus.wbValid    <= 1'b1;
              bus.wbRdEnable <= rd_en;
              bus.wbRdData   <= bus.exAddr;
            end
          end
        end
        StWait: begin
          if (cnt_q == 3'd0) begin
            bus.wbValid    <= 1'b1;
            bus.wbRdEnable <= ld_rd_en_q;
            bus.wbRdData   <= ld_ext;
            bus.exReady    <= 1'b1;
            state_q        <= StIdle;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance at RAM latency 1 with a one-doubleword RAM
// model, one at latency 3 for load timing and reset-during-wait behaviour.
module tb_mem_stage;

  logic clk;
  logic rst;
  logic rst3;
  int   n_tests;
  int   n_fail;

  mem_stage_if bus1 ();
  mem_stage_if bus3 ();

  mem_stage #(.RAM_LATENCY(1)) u_dut1 (.clk(clk), .rst(rst),  .bus(bus1));
  mem_stage #(.RAM_LATENCY(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: data is valid only in the cycle exactly L cycles after the strobe.
  logic [63:0] ram1_word;
  int unsigned rd1_cnt;
  int unsigned rd3_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram1_word <= 64'd0;
      rd1_cnt   <= 0;
      rd3_cnt   <= 0;
    end else begin
      if (bus1.RamWriteEnable)
        ram1_word <= (ram1_word & ~bus1.RamWriteMask) | (bus1.RamWriteData & bus1.RamWriteMask);
      if (bus1.RamReadEnable) rd1_cnt <= 1;
      else if (rd1_cnt != 0)  rd1_cnt <= rd1_cnt - 1;
      if (bus3.RamReadEnable) rd3_cnt <= 3;
      else if (rd3_cnt != 0)  rd3_cnt <= rd3_cnt - 1;
    end
  end

  assign bus1.RamReadData = (rd1_cnt == 1) ? ram1_word : 64'hdead_beef_0bad_f00d;
  assign bus3.RamReadData = (rd3_cnt == 1) ? 64'h0123_4567_89ab_cdef : 64'hdead_beef_0bad_f00d;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] sd,
                        input logic [4:0] rdaddr, input logic [63:0] pc);
    bus1.exValid     = 1'b1;
    bus1.exMemRead   = rd;
    bus1.exMemWrite  = wr;
    bus1.exFunct3    = f3;
    bus1.exAddr      = addr;
    bus1.exStoreData = sd;
    bus1.exRdEnable  = 1'b1;
    bus1.exRdAddr    = rdaddr;
    bus1.exPc        = pc;
    bus1.exInst      = pc[31:0] ^ 32'h0000_0013;
  endtask

  task automatic idle1();
    bus1.exValid    = 1'b0;
    bus1.exMemRead  = 1'b0;
    bus1.exMemWrite = 1'b0;
  endtask

  // Load on the latency-1 instance: strobe at T+1, WB pulse at T+3.
  task automatic load1(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] exp);
    drive1(1'b1, 1'b0, f3, addr, 64'd0, 5'd6, 64'h200);
    step();
    idle1();
    check({tag, "_ren"}, 64'(bus1.RamReadEnable), 64'd1);
    check({tag, "_raddr"}, bus1.RamReadAddr, {addr[63:3], 3'b000});
    check({tag, "_rdy_lo"}, 64'(bus1.exReady), 64'd0);
    step();
    check({tag, "_wbv_early"}, 64'(bus1.wbValid), 64'd0);
    step();
    check({tag, "_wbv"}, 64'(bus1.wbValid), 64'd1);
    check({tag, "_data"}, bus1.wbRdData, exp);
    check({tag, "_rden"}, 64'(bus1.wbRdEnable), 64'd1);
    check({tag, "_rdy_hi"}, 64'(bus1.exReady), 64'd1);
  endtask

  logic [63:0] alu_val [4];
  logic [4:0]  alu_rd  [4];
  int          cyc;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst  = 1'b0;
    rst3 = 1'b0;
    idle1();
    bus1.exFunct3 = 3'd0; bus1.exAddr = 64'd0; bus1.exStoreData = 64'd0;
    bus1.exRdEnable = 1'b0; bus1.exRdAddr = 5'd0; bus1.exPc = 64'd0; bus1.exInst = 32'd0;
    bus3.exValid = 1'b0; bus3.exMemRead = 1'b0; bus3.exMemWrite = 1'b0; bus3.exFunct3 = 3'd0;
    bus3.exAddr = 64'd0; bus3.exStoreData = 64'd0; bus3.exRdEnable = 1'b0;
    bus3.exRdAddr = 5'd0; bus3.exPc = 64'd0; bus3.exInst = 32'd0;
    alu_val[0] = 64'h0000_0000_0000_0011; alu_rd[0] = 5'd3;
    alu_val[1] = 64'hffff_ffff_ffff_fffe; alu_rd[1] = 5'd0;
    alu_val[2] = 64'h8000_0000_0000_0000; alu_rd[2] = 5'd7;
    alu_val[3] = 64'h0123_4567_89ab_cdef; alu_rd[3] = 5'd31;

    #3;
    check("rst_ready", 64'(bus1.exReady), 64'd0);
    check("rst_wbv", 64'(bus1.wbValid), 64'd0);
    check("rst_wmask", bus1.RamWriteMask, 64'd0);
    check("rst_ren", 64'(bus1.RamReadEnable), 64'd0);
    step();
    rst  = 1'b1;
    rst3 = 1'b1;
    step();
    check("post_rst_ready", 64'(bus1.exReady), 64'd1);

    // SD then LD of the same doubleword
    drive1(1'b0, 1'b1, 3'b011, 64'h8000_0010, 64'h1122_3344_5566_7788, 5'd5, 64'h100);
    step();
    idle1();
    check("sd_wen", 64'(bus1.RamWriteEnable), 64'd1);
    check("sd_waddr", bus1.RamWriteAddr, 64'h8000_0010);
    check("sd_mask", bus1.RamWriteMask, 64'hffff_ffff_ffff_ffff);
    check("sd_wdata", bus1.RamWriteData, 64'h1122_3344_5566_7788);
    check("sd_wbv", 64'(bus1.wbValid), 64'd1);
    check("sd_rden", 64'(bus1.wbRdEnable), 64'd0);
    step();
    check("sd_wen_off", 64'(bus1.RamWriteEnable), 64'd0);
    check("sd_wbv_off", 64'(bus1.wbValid), 64'd0);
    load1("ld", 3'b011, 64'h8000_0010, 64'h1122_3344_5566_7788);
    check("ld_pc", bus1.wbPc, 64'h200);
    check("ld_inst", 64'(bus1.wbInst), 64'h0000_0213);
    check("ld_rdaddr", 64'(bus1.wbRdAddr), 64'd6);

    // SB 0x80 into byte 3, then signed/unsigned extraction
    drive1(1'b0, 1'b1, 3'b000, 64'h8000_0013, 64'h1234_5678_9abc_de80, 5'd0, 64'h104);
    step();
    idle1();
    check("sb_mask", bus1.RamWriteMask, 64'h0000_0000_ff00_0000);
    check("sb_wdata", bus1.RamWriteData, 64'h789a_bcde_8000_0000);
    check("sb_waddr", bus1.RamWriteAddr, 64'h8000_0010);
    step();
    load1("lb", 3'b000, 64'h8000_0013, 64'hffff_ffff_ffff_ff80);
    load1("lbu", 3'b100, 64'h8000_0013, 64'h0000_0000_0000_0080);
    load1("lh", 3'b001, 64'h8000_0012, 64'hffff_ffff_ffff_8066);
    load1("lwu", 3'b110, 64'h8000_0014, 64'h0000_0000_1122_3344);

    // SH to lanes 6..7
    drive1(1'b0, 1'b1, 3'b001, 64'h8000_0016, 64'h0000_0000_0000_abcd, 5'd0, 64'h108);
    step();
    idle1();
    check("sh_mask", bus1.RamWriteMask, 64'hffff_0000_0000_0000);
    check("sh_wdata", bus1.RamWriteData, 64'habcd_0000_0000_0000);
    check("sh_waddr", bus1.RamWriteAddr, 64'h8000_0010);

    // Misaligned LW
    drive1(1'b1, 1'b0, 3'b010, 64'h8000_0012, 64'd0, 5'd9, 64'h10c);
    step();
    idle1();
    check("lw_mis_ren", 64'(bus1.RamReadEnable), 64'd0);
    check("lw_mis_wbv", 64'(bus1.wbValid), 64'd1);
    check("lw_mis_exc", 64'(bus1.wbExcept), 64'd1);
    check("lw_mis_rden", 64'(bus1.wbRdEnable), 64'd0);
    check("lw_mis_rdy", 64'(bus1.exReady), 64'd1);

    // Read and write together
    drive1(1'b1, 1'b1, 3'b011, 64'h8000_0010, 64'd0, 5'd9, 64'h110);
    step();
    idle1();
    check("rw_exc", 64'(bus1.wbExcept), 64'd1);
    check("rw_wen", 64'(bus1.RamWriteEnable), 64'd0);
    check("rw_ren", 64'(bus1.RamReadEnable), 64'd0);

    // Four back-to-back ALU ops
    for (int i = 0; i < 4; i++) begin
      drive1(1'b0, 1'b0, 3'b011, alu_val[i], 64'd0, alu_rd[i], 64'h300 + 64'(4 * i));
      step();
      check("alu_wbv", 64'(bus1.wbValid), 64'd1);
      check("alu_data", bus1.wbRdData, alu_val[i]);
      check("alu_rden", 64'(bus1.wbRdEnable), (alu_rd[i] != 5'd0) ? 64'd1 : 64'd0);
      check("alu_pc", bus1.wbPc, 64'h300 + 64'(4 * i));
    end
    idle1();
    step();
    check("alu_wbv_off", 64'(bus1.wbValid), 64'd0);

    // Latency 3: LHU with bounded wait for write-back
    bus3.exValid = 1'b1; bus3.exMemRead = 1'b1; bus3.exFunct3 = 3'b101;
    bus3.exAddr = 64'h8000_0016; bus3.exRdEnable = 1'b1; bus3.exRdAddr = 5'd4;
    bus3.exPc = 64'h400; bus3.exInst = 32'h0000_0403;
    step();
    bus3.exValid = 1'b0; bus3.exMemRead = 1'b0;
    check("l3_ren", 64'(bus3.RamReadEnable), 64'd1);
    cyc = 1;
    while (!bus3.wbValid && cyc < 10) begin
      check("l3_rdy_lo", 64'(bus3.exReady), 64'd0);
      step();
      cyc++;
    end
    check("l3_latency", 64'(cyc), 64'd5);
    check("l3_data", bus3.wbRdData, 64'h0000_0000_0000_0123);
    check("l3_rdy_hi", 64'(bus3.exReady), 64'd1);

    // Latency 3: reset one cycle into WAIT
    bus3.exValid = 1'b1; bus3.exMemRead = 1'b1; bus3.exFunct3 = 3'b011;
    bus3.exAddr = 64'h8000_0010; bus3.exPc = 64'h500;
    step();
    bus3.exValid = 1'b0; bus3.exMemRead = 1'b0;
    check("l3r_ren", 64'(bus3.RamReadEnable), 64'd1);
    step();
    rst3 = 1'b0;
    #1;
    check("l3r_rdy0", 64'(bus3.exReady), 64'd0);
    check("l3r_wbpc0", bus3.wbPc, 64'd0);
    check("l3r_raddr0", bus3.RamReadAddr, 64'd0);
    check("l3r_wbdata0", bus3.wbRdData, 64'd0);
    step();
    rst3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("l3r_no_wbv", 64'(bus3.wbValid), 64'd0);
      step();
    end
    check("l3r_rdy1", 64'(bus3.exReady), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Load/store stage of the zerocore pipeline, directly downstream of the execute stage and upstream of register write-back. It accepts one instruction per handshake from EX and passes ALU results straight through. For loads and stores it drives the data-RAM port with a doubleword-aligned address and a 64-bit bit mask. Load data is returned after a fixed RAM latency, sign- or zero-extended, and presented to write-back with the PC/instruction for difftest.

## Interface
- RAM_LATENCY, 1, cycles from the RamReadEnable strobe cycle to the cycle RamReadData is valid (legal 1..4)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- exValid  in  1  EX presents an instruction
- exReady  out  1  stage can accept this cycle
- exMemRead / exMemWrite  in  1 each  load / store
- exFunct3  in  3  RV64 width code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- exAddr  in  64  ALU result: effective address, or rd data for non-memory ops
- exStoreData  in  64  rs2 value
- exRdEnable  in  1, exRdAddr  in  5  destination
- exPc  in  64, exInst  in  32  difftest pass-through
- RamReadEnable  out  1, RamReadAddr  out  64
- RamReadData  in  64
- RamWriteEnable  out  1, RamWriteAddr  out  64, RamWriteMask  out  64, RamWriteData  out  64
- wbValid  out  1  one-cycle pulse per retired instruction
- wbRdEnable  out  1, wbRdAddr  out  5, wbRdData  out  64
- wbPc  out  64, wbInst  out  32
- wbExcept  out  1  misaligned or illegal access

## Operation
- FSM states:
  - IDLE: exReady=1.
  - WAIT: exReady=0, latency counter running.
- Accept = exValid & exReady, sampled on the rising edge.
- Non-memory op: registers wbRdData=exAddr. wbValid next cycle. No RAM strobe.
- Misalignment: B always aligned; H needs addr[0]=0; W/WU needs addr[1:0]=0; D needs addr[2:0]=0.
- Misaligned access, or exMemRead&exMemWrite together:
  - No RAM strobe.
  - wbValid with wbExcept=1 and wbRdEnable=0.
  - Stays in IDLE.
- Store (aligned):
  - RamWriteEnable=1 for exactly one cycle after accept.
  - RamWriteAddr = {addr[63:3],3'b0}.
  - RamWriteMask has 0xFF in each byte lane covered by the access. Lane = addr[2:0]; width 1/2/4/8 bytes.
  - RamWriteData = exStoreData << (8*addr[2:0]).
  - wbValid in the same cycle, wbRdEnable=0. Stays in IDLE.
- Load (aligned):
  - RamReadEnable=1 and RamReadAddr = aligned address for one cycle after accept.
  - Enters WAIT with counter = RAM_LATENCY.
  - Counter decrements each cycle. RamReadData is sampled in the cycle the counter reaches 0, then the FSM returns to IDLE.
  - Extraction: shift right by 8*addr[2:0], truncate to width. Sign-extend for B/H/W, zero-extend for BU/HU/WU; D is unchanged.
- wbRdEnable = exRdEnable & (exRdAddr≠0) for non-excepting ops. x0 writes are never signalled.
- wbPc, wbInst, wbRdAddr are always the accepted instruction's values.
- RAM outputs are registered. When not strobing: RamRead/WriteEnable=0, and mask/data/addresses hold 0.

## Timing
- Reset (rst=0, asynchronous): state IDLE, counter 0, every output 0 except exReady=1 once out of reset.
- Accept at edge ending cycle T:
  - ALU, store and exception ops: wbValid in cycle T+1. Any store strobe is also in T+1. Back-to-back accepts give 1 instruction per cycle.
  - Load: strobe in cycle S=T+1. RamReadData is valid in cycle S+L and is sampled at the end of that cycle. wbValid in cycle S+L+1.
  - exReady is low for cycles S..S+L and high again in S+L+1, when a new accept is allowed in the same cycle as the WB pulse.
- Throughput: one load per L+2 cycles.
- exValid while exReady=0: no effect; EX must hold its inputs.
- Reset asserted during WAIT: returns to IDLE immediately. A late RamReadData is ignored and no wbValid is produced.
- wbValid is never high for two consecutive cycles for the same instruction.

## Test plan
- RAM_LATENCY=1, SD 0x1122334455667788 to 0x80000010, then LD from the same address:
  - Store: RamWriteMask all-ones, RamWriteAddr 0x80000010.
  - Load: wbRdData 0x1122334455667788, wbValid 3 cycles after the load accept.
- Memory doubleword with 0x80 at byte 3, load from addr ...3:
  - LB: wbRdData 0xFFFFFFFFFFFFFF80.
  - LBU: wbRdData 0x0000000000000080.
- SH data 0xABCD to addr 0x...6: RamWriteMask 0xFFFF000000000000, RamWriteData 0xABCD000000000000, addr bits [2:0]=0.
- LW at 0x...2: no RamReadEnable; wbValid with wbExcept=1 and wbRdEnable=0, in cycle T+1.
- Four back-to-back ALU ops, one with rd=x0: four consecutive wbValid pulses with the matching data; the x0 op has wbRdEnable=0.
- RAM_LATENCY=3, assert rst=0 one cycle into WAIT:
  - All outputs drop to 0 asynchronously.
  - After release: exReady=1 and no spurious wbValid.
